// File: rtl/quad_pkg.sv
// Shared types for the quadrature decoder: FSM states, Gray-code phase
// constants and the phase-sequence helper used by the decode logic.
package quad_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_10 = 2'b10;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_01 = 2'b01;

  // Phase {a,b} one position forward (up=1) or backward (up=0).
  function automatic phase_t next_phase(input phase_t ph, input logic up);
    phase_t nxt;
    nxt = PH_00;
    case (ph)
      PH_00:   nxt = up ? PH_10 : PH_01;
      PH_10:   nxt = up ? PH_11 : PH_00;
      PH_11:   nxt = up ? PH_01 : PH_10;
      default: nxt = up ? PH_00 : PH_11;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder channel: two-flop synchronizer followed by a persistence
// filter that accepts a new level only after FILTER_LEN consecutive samples.
module quad_glitch_filter #(
  parameter int FILTER_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic level_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample agreeing with the accepted level restarts the persistence count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: filtered A/B phases drive a step/direction stream,
// a wrapping position count and a sticky illegal-transition flag.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int N          = 4,
  parameter int FILTER_LEN = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         pause,
  input  logic         clear_err,
  input  logic         quad_a,
  input  logic         quad_b,
  output logic         step,
  output logic         up_down,
  output logic [N-1:0] count,
  output logic         error
);

  // INIT covers the synchronizer plus filter fill time so a non-zero
  // input level present at reset is absorbed without producing a step.
  localparam int ICW = $clog2(FILTER_LEN + 3);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(FILTER_LEN + 2);

  logic a_f, b_f;
  phase_t phase;

  state_e         state_q, state_d;
  logic [ICW-1:0] init_cnt_q, init_cnt_d;
  phase_t         prev_q, prev_d;
  logic           step_q, step_d;
  logic           up_down_q, up_down_d;
  logic [N-1:0]   count_q, count_d;
  logic           error_q, error_d;

  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk    (clk),
    .reset  (reset),
    .in_i   (quad_a),
    .level_o(a_f)
  );

  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk    (clk),
    .reset  (reset),
    .in_i   (quad_b),
    .level_o(b_f)
  );

  assign phase = {a_f, b_f};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      prev_q     <= PH_00;
      step_q     <= 1'b0;
      up_down_q  <= 1'b0;
      count_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      up_down_q  <= up_down_d;
      count_q    <= count_d;
      error_q    <= error_d;
    end
  end

  // prev always follows the filtered phase, so a disabled period leaves no
  // stale phase behind; error clear is applied first so a new set wins.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = phase;
    step_d     = 1'b0;
    up_down_d  = up_down_q;
    count_d    = count_q;
    error_d    = error_q & ~clear_err;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + ICW'(1);
        end
      end
      ST_RUN: begin
        if (enable) begin
          if (phase == next_phase(prev_q, 1'b1)) begin
            step_d    = 1'b1;
            up_down_d = 1'b1;
            if (!pause) count_d = count_q + N'(1);
          end else if (phase == next_phase(prev_q, 1'b0)) begin
            step_d    = 1'b1;
            up_down_d = 1'b0;
            if (!pause) count_d = count_q - N'(1);
          end else if ((phase ^ prev_q) == 2'b11) begin
            error_d = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign step    = step_q;
  assign up_down = up_down_q;
  assign count   = count_q;
  assign error   = error_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder: directed scenarios plus a
// randomized move sequence scored against a position-index reference model.
module tb_quadrature_decoder;

  localparam int N         = 4;
  localparam int FL        = 2;
  localparam int HOLD      = 8;
  localparam int STEP_EDGE = FL + 3;
  localparam int MOD       = 1 << N;

  logic clk = 1'b0;
  logic reset = 1'b0, enable = 1'b1, pause = 1'b0, clear_err = 1'b0;
  logic quad_a = 1'b0, quad_b = 1'b0;
  logic step, up_down, error;
  logic [N-1:0] count;

  int checks = 0;
  int errors = 0;

  // Reference model state: phase position, count, direction, error flag.
  logic [1:0] m_phase = 2'b00;
  int         m_count = 0;
  logic       m_dir = 1'b0;
  logic       m_err = 1'b0;
  int         m_pulses, m_edge;
  int         obs_pulses, obs_edge;

  logic [1:0] up_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  always #5 clk = ~clk;

  quadrature_decoder #(.N(N), .FILTER_LEN(FL)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .pause    (pause),
    .clear_err(clear_err),
    .quad_a   (quad_a),
    .quad_b   (quad_b),
    .step     (step),
    .up_down  (up_down),
    .count    (count),
    .error    (error)
  );

  function automatic int ph_idx(input logic [1:0] ph);
    case (ph)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ph_up(input logic [1:0] ph);
    return up_seq[(ph_idx(ph) + 1) % 4];
  endfunction

  function automatic logic [1:0] ph_down(input logic [1:0] ph);
    return up_seq[(ph_idx(ph) + 3) % 4];
  endfunction

  // Distance around the 4-position cycle decides up, down or illegal.
  function automatic void model_move(input logic [1:0] ph, input logic en, input logic pz);
    int d;
    d = (ph_idx(ph) - ph_idx(m_phase) + 4) % 4;
    m_pulses = 0;
    m_edge   = -1;
    if (en) begin
      if (d == 1 || d == 3) begin
        m_pulses = 1;
        m_edge   = STEP_EDGE;
        m_dir    = (d == 1);
        if (!pz) m_count = (m_count + ((d == 1) ? 1 : -1) + MOD) % MOD;
      end else if (d == 2) begin
        m_err = 1'b1;
      end
    end
    m_phase = ph;
  endfunction

  task automatic apply_move(input logic [1:0] ph, input int clr_edge,
                            output int pulses, output int first_edge);
    @(negedge clk);
    {quad_a, quad_b} = ph;
    clear_err = (clr_edge == 1);
    pulses = 0;
    first_edge = -1;
    for (int k = 1; k <= HOLD; k++) begin
      @(posedge clk);
      #1;
      if (step !== 1'b0) begin
        pulses++;
        if (first_edge < 0) first_edge = k;
      end
      clear_err = (clr_edge == k + 1);
    end
  endtask

  task automatic watch_steps(input int cycles, output int pulses);
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (step !== 1'b0) pulses++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (step !== 1'b0) begin errors++; $display("[TB] FAIL reset_step got %b expected 0", step); end
    checks++; if (up_down !== 1'b0) begin errors++; $display("[TB] FAIL reset_up_down got %b expected 0", up_down); end
    checks++; if (count !== '0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", count); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got %b expected 0", error); end
    m_count = 0; m_dir = 1'b0; m_err = 1'b0; m_phase = {quad_a, quad_b};
    watch_steps(HOLD, obs_pulses);
    checks++; if (obs_pulses != 0) begin errors++; $display("[TB] FAIL init_no_step got %0d pulses expected 0", obs_pulses); end
  endtask

  task automatic test_up();
    for (int i = 0; i < 4; i++) begin
      model_move(ph_up(m_phase), enable, pause);
      apply_move(m_phase, 0, obs_pulses, obs_edge);
      checks++; if (obs_pulses != 1) begin errors++; $display("[TB] FAIL up_pulses[%0d] got %0d expected 1", i, obs_pulses); end
      checks++; if (obs_edge != STEP_EDGE) begin errors++; $display("[TB] FAIL up_latency[%0d] got edge %0d expected %0d", i, obs_edge, STEP_EDGE); end
      checks++; if (count !== N'(i + 1)) begin errors++; $display("[TB] FAIL up_count[%0d] got %0d expected %0d", i, count, i + 1); end
      checks++; if (up_down !== 1'b1) begin errors++; $display("[TB] FAIL up_dir[%0d] got %b expected 1", i, up_down); end
    end
  endtask

  task automatic test_down_wrap();
    int exp_cnt [5] = '{3, 2, 1, 0, 15};
    for (int i = 0; i < 5; i++) begin
      model_move(ph_down(m_phase), enable, pause);
      apply_move(m_phase, 0, obs_pulses, obs_edge);
      checks++; if (obs_pulses != 1) begin errors++; $display("[TB] FAIL down_pulses[%0d] got %0d expected 1", i, obs_pulses); end
      checks++; if (count !== N'(exp_cnt[i])) begin errors++; $display("[TB] FAIL down_count[%0d] got %0d expected %0d", i, count, exp_cnt[i]); end
      checks++; if (up_down !== 1'b0) begin errors++; $display("[TB] FAIL down_dir[%0d] got %b expected 0", i, up_down); end
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    quad_a = ~quad_a;
    @(posedge clk);
    #1;
    quad_a = ~quad_a;
    obs_pulses = (step !== 1'b0) ? 1 : 0;
    watch_steps(HOLD, obs_edge);
    obs_pulses += obs_edge;
    checks++; if (obs_pulses != 0) begin errors++; $display("[TB] FAIL glitch_step got %0d pulses expected 0", obs_pulses); end
    checks++; if (count !== N'(m_count)) begin errors++; $display("[TB] FAIL glitch_count got %0d expected %0d", count, m_count); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL glitch_error got %b expected 0", error); end
  endtask

  task automatic test_illegal();
    model_move(m_phase ^ 2'b11, enable, pause);
    apply_move(m_phase, 0, obs_pulses, obs_edge);
    checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL illegal_error got %b expected 1", error); end
    checks++; if (obs_pulses != 0) begin errors++; $display("[TB] FAIL illegal_step got %0d pulses expected 0", obs_pulses); end
    checks++; if (count !== N'(m_count)) begin errors++; $display("[TB] FAIL illegal_count got %0d expected %0d", count, m_count); end
    checks++; if (up_down !== m_dir) begin errors++; $display("[TB] FAIL illegal_dir got %b expected %b", up_down, m_dir); end
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    m_err = 1'b0;
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL clear_err got %b expected 0", error); end
    m_err = 1'b0;
    model_move(m_phase ^ 2'b11, enable, pause);
    apply_move(m_phase, STEP_EDGE, obs_pulses, obs_edge);
    checks++; if (error !== m_err) begin errors++; $display("[TB] FAIL set_wins got %b expected %b", error, m_err); end
  endtask

  task automatic test_pause_enable();
    pause = 1'b1;
    for (int i = 0; i < 2; i++) begin
      model_move(ph_up(m_phase), enable, pause);
      apply_move(m_phase, 0, obs_pulses, obs_edge);
      checks++; if (obs_pulses != 1) begin errors++; $display("[TB] FAIL pause_pulses[%0d] got %0d expected 1", i, obs_pulses); end
      checks++; if (count !== N'(m_count)) begin errors++; $display("[TB] FAIL pause_count[%0d] got %0d expected %0d", i, count, m_count); end
    end
    pause = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_move(ph_up(m_phase), enable, pause);
      apply_move(m_phase, 0, obs_pulses, obs_edge);
      checks++; if (obs_pulses != 0) begin errors++; $display("[TB] FAIL disabled_pulses[%0d] got %0d expected 0", i, obs_pulses); end
      checks++; if (count !== N'(m_count)) begin errors++; $display("[TB] FAIL disabled_count[%0d] got %0d expected %0d", i, count, m_count); end
    end
    @(negedge clk);
    enable = 1'b1;
    watch_steps(HOLD, obs_pulses);
    checks++; if (obs_pulses != 0) begin errors++; $display("[TB] FAIL reenable_step got %0d pulses expected 0", obs_pulses); end
  endtask

  task automatic test_random();
    logic [1:0] nxt;
    int r;
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    m_err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      nxt = m_phase ^ 2'b11;
      else if (r < 4)  nxt = ph_down(m_phase);
      else             nxt = ph_up(m_phase);
      enable = ($urandom_range(0, 4) != 0);
      pause  = ($urandom_range(0, 3) == 0);
      model_move(nxt, enable, pause);
      apply_move(nxt, 0, obs_pulses, obs_edge);
      checks++; if (obs_pulses != m_pulses || obs_edge != m_edge) begin errors++; $display("[TB] FAIL rand_step[%0d] got %0d pulses at %0d expected %0d at %0d", i, obs_pulses, obs_edge, m_pulses, m_edge); end
      checks++; if (count !== N'(m_count)) begin errors++; $display("[TB] FAIL rand_count[%0d] got %0d expected %0d", i, count, m_count); end
      checks++; if (up_down !== m_dir) begin errors++; $display("[TB] FAIL rand_dir[%0d] got %b expected %b", i, up_down, m_dir); end
      checks++; if (error !== m_err) begin errors++; $display("[TB] FAIL rand_error[%0d] got %b expected %b", i, error, m_err); end
    end
    enable = 1'b1;
    pause  = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_count = 0; m_dir = 1'b0; m_err = 1'b0; m_phase = {quad_a, quad_b};
    watch_steps(HOLD, obs_pulses);
    enable = 1'b0;
    for (int i = 0; i < 4 && m_phase != 2'b01; i++) begin
      model_move(ph_up(m_phase), enable, pause);
      apply_move(m_phase, 0, obs_pulses, obs_edge);
    end
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      model_move(ph_up(m_phase), enable, pause);
      apply_move(m_phase, 0, obs_pulses, obs_edge);
    end
    checks++; if (count !== N'(7) || {quad_a, quad_b} !== 2'b11) begin errors++; $display("[TB] FAIL setup_count7 got %0d expected 7", count); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (count !== '0) begin errors++; $display("[TB] FAIL midreset_count got %0d expected 0", count); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL midreset_error got %b expected 0", error); end
    m_count = 0; m_dir = 1'b0; m_err = 1'b0;
    watch_steps(HOLD, obs_pulses);
    checks++; if (obs_pulses != 0) begin errors++; $display("[TB] FAIL midreset_init_step got %0d pulses expected 0", obs_pulses); end
    model_move(2'b01, enable, pause);
    apply_move(2'b01, 0, obs_pulses, obs_edge);
    checks++; if (count !== N'(1)) begin errors++; $display("[TB] FAIL post_reset_count got %0d expected 1", count); end
    checks++; if (obs_pulses != 1) begin errors++; $display("[TB] FAIL post_reset_step got %0d pulses expected 1", obs_pulses); end
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog timeout reached expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_up();
    test_down_wrap();
    test_glitch();
    test_illegal();
    test_pause_enable();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
- Decodes two-channel quadrature inputs (quad_a, quad_b) into one-cycle step pulses, a direction bit and a wrapping N-bit position count.
- Produces the step/direction stream that drives up/down counting from a physical encoder, and keeps its own position count.
- Contains an input synchronizer, a glitch filter, a decode FSM and an illegal-transition detector.

Parameters:
- N, 4, position count width; count wraps modulo 2^N.
- FILTER_LEN, 2, consecutive cycles a synchronized input must hold a new level before it is accepted; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = decode transitions; 0 = track inputs silently.
- pause  input  1  1 = hold count; step and up_down still update.
- clear_err  input  1  clears the sticky error flag.
- quad_a  input  1  asynchronous encoder channel A.
- quad_b  input  1  asynchronous encoder channel B.
- step  output  1  one-cycle pulse per valid decoded transition.
- up_down  output  1  direction of the last valid transition; 1 = up.
- count  output  N  position count.
- error  output  1  sticky flag for an illegal transition.

Behaviour:
- Reset. One clock; reset is synchronous and active-high. The following clear to 0: step, up_down, count, error, both synchronizer stages, filtered levels, filter counters and the previous-phase register. The FSM enters INIT.
- Synchronizer. Two flops per channel. A level first sampled at edge 1 appears on the second stage after edge 2.
- Filter, per channel:
  - The counter increments on each edge where sync2 differs from the filtered level, and resets to 0 when they match.
  - When sync2 still differs and the counter equals FILTER_LEN-1, the filtered level takes sync2 and the counter clears.
  - A held change updates the filtered level at edge FILTER_LEN+2.
  - Counter width is clog2(FILTER_LEN+1).
- Phase is {a_f, b_f}.
  - Up order: 00→10→11→01→00.
  - Down order: the reverse.
- FSM INIT:
  - Lasts FILTER_LEN+3 edges after reset deasserts. The previous phase loads from the filtered phase every cycle.
  - No step, no count change, no error.
  - Then moves to RUN.
- FSM RUN: each edge, compare the filtered phase with the previous phase.
  - Equal: nothing happens.
  - One bit changed (up or down order), with enable=1:
    - step=1 for exactly one cycle; up_down is set to the direction.
    - If pause=0, count is incremented or decremented by 1.
  - Both bits changed, with enable=1: error is set; no step; count and up_down are unchanged.
  - enable=0: no step, no count change, no error.
  - In all cases the previous phase is updated to the filtered phase, so re-enabling never produces a spurious step.
- Latency. A clean input change first sampled at edge 1 asserts step, and updates count, at edge FILTER_LEN+3. All outputs are registered.
- Wrap-around. Up from 2^N-1 gives 0; down from 0 gives 2^N-1. No saturation.
- Simultaneous events:
  - If an error set and clear_err occur in the same cycle, the flag is set (set wins).
  - reset overrides everything, including mid-transition filter state; the FSM returns to INIT.
- Edge rate. Inputs changing faster than once per FILTER_LEN+1 cycles are not guaranteed to decode; only the both-bits-in-one-cycle case is flagged.

Decomposition:
- Package quad_pkg holds:
  - the FSM state encoding (ST_INIT, ST_RUN);
  - the phase constants PH_00, PH_10, PH_11, PH_01;
  - a next-up/next-down phase function.
- Sub-module quad_glitch_filter: 2-flop synchronizer plus the filter counter for one channel, parameterized by FILTER_LEN, instantiated twice.
- The top level holds the FSM, decode, count and error logic.

Test Plan:
- Up sequence: reset with A=B=0, then wait INIT. Apply 00→10→11→01→00, each step held 8 cycles. Expect 4 step pulses, up_down=1, count 0→4, each step at edge FILTER_LEN+3 (5) after the first sampling edge.
- Down with wrap: from count=4, apply 5 down transitions. Expect 5 step pulses, up_down=0, count 3,2,1,0,15.
- Glitch rejection: drive a 1-cycle pulse on A (shorter than FILTER_LEN). Expect no step, count unchanged, error=0.
- Illegal transition: drive 00→11 in one cycle. Expect error=1, no step, count and up_down unchanged. Pulse clear_err and expect error=0. Assert clear_err in the same cycle as a new illegal transition and expect error stays 1.
- Pause and enable:
  - pause=1 over 2 up transitions: expect 2 step pulses, count held.
  - enable=0 over 2 transitions: expect no steps, no count change.
  - Re-enable with static inputs: expect no step.
- Reset mid-operation: at count=7 with inputs at 11, assert reset for 1 cycle. Expect count=0, error=0 and no step through INIT. The next up transition (11→01) gives count=1.
